// File: rtl/sram_1rw_arbiter.sv
// sram_1rw_arbiter: round-robin arbiter and sequencer for a single-port 1RW SRAM macro
// with a shared tristate data bus and active-low CSb/WEb/OEb.
module sram_1rw_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    inout  wire  [DATA_WIDTH-1:0] sram_data,
    output logic                  sram_csb,
    output logic                  sram_web,
    output logic                  sram_oeb
);
    typedef enum logic [1:0] {IDLE, WRITE, RD_CMD, RD_DATA} state_t;

    state_t                state, state_nx;
    logic                  last_grant, gnt, take, nx_we;
    logic [DATA_WIDTH-1:0] wdata_q;

    always_comb begin
        gnt        = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        take       = (state != RD_CMD) && (req0_valid || req1_valid);
        req0_ready = take && !gnt;
        req1_ready = take && gnt;
        nx_we      = gnt ? req1_we : req0_we;
        state_nx   = take ? (nx_we ? WRITE : RD_CMD) : (state == RD_CMD) ? RD_DATA : IDLE;
    end

    // last_grant doubles as the owner of the operation in flight
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            sram_addr  <= '0;
            wdata_q    <= '0;
            sram_csb   <= 1'b1;
            sram_web   <= 1'b1;
            sram_oeb   <= 1'b1;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
        end else begin
            state      <= state_nx;
            sram_csb   <= state_nx == IDLE;
            sram_web   <= state_nx != WRITE;
            sram_oeb   <= state_nx != RD_DATA;
            rsp0_valid <= state == RD_DATA && !last_grant;
            rsp1_valid <= state == RD_DATA && last_grant;
            if (state == RD_DATA && !last_grant) rsp0_rdata <= sram_data;
            if (state == RD_DATA && last_grant) rsp1_rdata <= sram_data;
            if (take) begin
                last_grant <= gnt;
                sram_addr  <= gnt ? req1_addr : req0_addr;
                wdata_q    <= gnt ? req1_wdata : req0_wdata;
            end
        end
    end

    // web low exactly in WRITE, the only state in which the controller owns the bus
    assign sram_data = sram_web ? 'z : wdata_q;
endmodule

// File: tb/tb_sram_1rw_arbiter.sv
// tb_sram_1rw_arbiter: directed bench with a behavioural 1RW SRAM macro model
// (read data appears 3 time units after OEb falls).
module tb_sram_1rw_arbiter;
    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        req0_valid = 1'b0, req0_we = 1'b0, req1_valid = 1'b0, req1_we = 1'b0;
    logic [10:0] req0_addr = '0, req1_addr = '0;
    logic [31:0] req0_wdata = '0, req1_wdata = '0;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic [10:0] sram_addr;
    wire  [31:0] sram_data;
    logic        sram_csb, sram_web, sram_oeb;
    int          total = 0, bad = 0;

    sram_1rw_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(11)) dut (
        .clk(clk), .rstb(rstb),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .sram_addr(sram_addr), .sram_data(sram_data),
        .sram_csb(sram_csb), .sram_web(sram_web), .sram_oeb(sram_oeb)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:2047];
    logic [31:0] mq = '0;
    logic        oe_d = 1'b0;

    always @(posedge clk) begin
        if (!sram_csb && !sram_web) mem[sram_addr] <= sram_data;
        if (!sram_csb && sram_web) mq <= mem[sram_addr];
    end

    always @(sram_oeb) begin
        if (sram_oeb) oe_d = 1'b0;
        else begin
            #3;
            oe_d = !sram_oeb;
        end
    end

    assign sram_data = (!sram_oeb && oe_d) ? mq : 'z;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int c, input logic v, input logic we, input logic [10:0] a,
                           input logic [31:0] d);
        if (c == 0) begin
            req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
        end
    endtask

    task automatic do_write(input int c, input logic [10:0] a, input logic [31:0] d);
        @(negedge clk);
        set_req(c, 1'b1, 1'b1, a, d);
        #1 chk("wr_ready", c == 0 ? req0_ready : req1_ready, 1);
        @(negedge clk);
        set_req(c, 1'b0, 1'b0, '0, '0);
        chk("wr_addr", sram_addr, a);
        chk("wr_web", sram_web, 0);
        chk("wr_bus", sram_data, d);
        @(negedge clk);
    endtask

    task automatic do_read(input int c, input logic [10:0] a, input logic [31:0] e);
        @(negedge clk);
        set_req(c, 1'b1, 1'b0, a, '0);
        #1 chk("rd_ready", c == 0 ? req0_ready : req1_ready, 1);
        @(negedge clk);
        set_req(c, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        chk("rd_valid", c == 0 ? rsp0_valid : rsp1_valid, 1);
        chk("rd_other", c == 0 ? rsp1_valid : rsp0_valid, 0);
        chk("rd_data", c == 0 ? rsp0_rdata : rsp1_rdata, e);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_csb", sram_csb, 1);
        chk("rst_web", sram_web, 1);
        chk("rst_oeb", sram_oeb, 1);
        chk("rst_addr", sram_addr, 0);
        chk("rst_rsp", {rsp0_valid, rsp1_valid}, 0);
        chk("rst_rdata", {rsp0_rdata, rsp1_rdata}, 0);
        rstb = 1'b1;

        // write then read accepted straight out of WRITE
        @(negedge clk);
        set_req(0, 1'b1, 1'b1, 11'h005, 32'hDEADBEEF);
        #1 chk("t1_rdy_wr", req0_ready, 1);
        @(negedge clk);
        chk("t1_csb", sram_csb, 0);
        chk("t1_web", sram_web, 0);
        chk("t1_oeb", sram_oeb, 1);
        chk("t1_addr", sram_addr, 11'h005);
        chk("t1_bus", sram_data, 32'hDEADBEEF);
        set_req(0, 1'b1, 1'b0, 11'h005, '0);
        #1 chk("t1_rdy_rd", req0_ready, 1);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, '0, '0);
        chk("t1_rdcmd", {sram_csb, sram_web, sram_oeb}, 3'b011);
        @(negedge clk);
        chk("t1_rddata", {sram_csb, sram_web, sram_oeb}, 3'b010);
        chk("t1_early", rsp0_valid, 0);
        @(negedge clk);
        chk("t1_valid", rsp0_valid, 1);
        chk("t1_rdata", rsp0_rdata, 32'hDEADBEEF);
        chk("t1_rsp1", rsp1_valid, 0);
        chk("t1_idle", sram_csb, 1);
        @(negedge clk);
        chk("t1_pulse", rsp0_valid, 0);
        chk("t1_hold", rsp0_rdata, 32'hDEADBEEF);

        // tie after reset goes to client 0, then client 1 on the next cycle
        rstb = 1'b0;
        @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        set_req(0, 1'b1, 1'b1, 11'h010, 32'h11111111);
        set_req(1, 1'b1, 1'b1, 11'h011, 32'h22222222);
        #1 chk("t2_rdy", {req0_ready, req1_ready}, 2'b10);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, '0, '0);
        chk("t2_rdy1", {req0_ready, req1_ready}, 2'b01);
        chk("t2_w0", {sram_web, sram_addr, sram_data}, {1'b0, 11'h010, 32'h11111111});
        @(negedge clk);
        set_req(1, 1'b0, 1'b0, '0, '0);
        chk("t2_w1", {sram_web, sram_addr, sram_data}, {1'b0, 11'h011, 32'h22222222});
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 11'h010, '0);
        set_req(1, 1'b1, 1'b0, 11'h011, '0);
        #1 chk("t2_rrdy", {req0_ready, req1_ready}, 2'b10);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, '0, '0);
        chk("t2_rdcmd_rdy", {req0_ready, req1_ready}, 2'b00);
        @(negedge clk);
        chk("t2_rddata_rdy", req1_ready, 1);
        @(negedge clk);
        set_req(1, 1'b0, 1'b0, '0, '0);
        chk("t2_rsp0", {rsp0_valid, rsp1_valid, rsp0_rdata}, {2'b10, 32'h11111111});
        @(negedge clk);
        @(negedge clk);
        chk("t2_rsp1", {rsp0_valid, rsp1_valid, rsp1_rdata}, {2'b01, 32'h22222222});

        // continuous reads from both clients alternate, one accept per 2 cycles
        do_write(0, 11'h001, 32'h0000000A);
        do_write(1, 11'h002, 32'h0000000B);
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 11'h001, '0);
        set_req(1, 1'b1, 1'b0, 11'h002, '0);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk("t3_rdy0", req0_ready, i % 4 == 0);
            chk("t3_rdy1", req1_ready, i % 4 == 2);
            chk("t3_v0", rsp0_valid, i % 4 == 3);
            chk("t3_v1", rsp1_valid, i >= 5 && i % 4 == 1);
            if (i % 4 == 3) chk("t3_d0", rsp0_rdata, 32'h0000000A);
            if (i >= 5 && i % 4 == 1) chk("t3_d1", rsp1_rdata, 32'h0000000B);
        end
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("t3_last", {rsp1_valid, rsp1_rdata}, {1'b1, 32'h0000000B});
        repeat (2) @(negedge clk);

        // read then write from the other client, handed over in RD_DATA
        set_req(0, 1'b1, 1'b0, 11'h005, '0);
        #1 chk("t4_rdy0", req0_ready, 1);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b1, 1'b1, 11'h020, 32'h12345678);
        #1 chk("t4_rdcmd_rdy", req1_ready, 0);
        @(negedge clk);
        chk("t4_oeb", sram_oeb, 0);
        chk("t4_rbus", sram_data, 32'hDEADBEEF);
        chk("t4_rdy1", req1_ready, 1);
        @(negedge clk);
        set_req(1, 1'b0, 1'b0, '0, '0);
        chk("t4_ctl", {sram_csb, sram_web, sram_oeb}, 3'b001);
        chk("t4_wbus", sram_data, 32'h12345678);
        chk("t4_rsp", {rsp0_valid, rsp0_rdata}, {1'b1, 32'hDEADBEEF});
        do_read(1, 11'h020, 32'h12345678);

        // reset during RD_CMD aborts with no response
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 11'h001, '0);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, '0, '0);
        chk("t5_rdcmd", sram_csb, 0);
        rstb = 1'b0;
        #1;
        chk("t5_ctl", {sram_csb, sram_web, sram_oeb}, 3'b111);
        chk("t5_addr", sram_addr, 0);
        repeat (3) begin
            @(negedge clk);
            chk("t5_norsp", {rsp0_valid, rsp1_valid}, 0);
        end
        rstb = 1'b1;
        @(negedge clk);
        set_req(0, 1'b1, 1'b1, 11'h003, 32'h3);
        set_req(1, 1'b1, 1'b1, 11'h004, 32'h4);
        #1 chk("t5_tie", {req0_ready, req1_ready}, 2'b10);
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);

        // address extremes
        do_write(0, 11'h000, 32'hCAFEF00D);
        do_write(1, 11'h7FF, 32'h0BADC0DE);
        do_read(0, 11'h7FF, 32'h0BADC0DE);
        do_read(1, 11'h000, 32'hCAFEF00D);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=0 exp=1");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sram_1rw_arbiter.md
Name: sram_1rw_arbiter

Overview:
Two-requester arbiter and sequencer for the single-port 1RW SRAM macro with a bidirectional DATA bus and active-low CSb/WEb/OEb.
- Accepts read/write requests from two independent valid/ready clients and grants them round-robin.
- Drives the macro's control, address and tristate data bus with registered signals.
- Captures read data and returns it to the owning client.
- Sits between the client logic and the SRAM macro.

Parameters:
DATA_WIDTH, 32, SRAM word width
ADDR_WIDTH, 11, SRAM address width (depth 1<<ADDR_WIDTH)

Ports:
clk  input  1  clock; all state updates on rising edge
rstb  input  1  asynchronous active-low reset
req0_valid  input  1  client 0 request valid
req0_ready  output  1  client 0 request accepted this cycle
req0_we  input  1  client 0: 1=write, 0=read
req0_addr  input  ADDR_WIDTH  client 0 address
req0_wdata  input  DATA_WIDTH  client 0 write data
rsp0_valid  output  1  client 0 read data valid (1-cycle pulse)
rsp0_rdata  output  DATA_WIDTH  client 0 read data
req1_valid / req1_ready / req1_we / req1_addr / req1_wdata / rsp1_valid / rsp1_rdata: as client 0, for client 1
sram_addr  output  ADDR_WIDTH  to macro ADDR
sram_data  inout  DATA_WIDTH  to macro DATA
sram_csb  output  1  to macro CSb
sram_web  output  1  to macro WEb
sram_oeb  output  1  to macro OEb

Behaviour:
- Reset (rstb low, asynchronous):
  - state=IDLE; sram_csb=1, sram_web=1, sram_oeb=1, sram_addr=0; sram_data released (z).
  - rsp*_valid=0, rsp*_rdata=0, last_grant=1 (client 0 wins first tie).
  - Reset mid-operation aborts the operation; no response is issued.
- FSM states:
  - IDLE: csb=1, web=1, oeb=1.
  - WRITE: csb=0, web=0, oeb=1; controller drives sram_data = latched wdata.
  - RD_CMD: csb=0, web=1, oeb=1; sram_data released.
  - RD_DATA: csb=0, web=1, oeb=0; same address held; sram_data released.
- Accept states: IDLE, WRITE and RD_DATA, i.e. the last cycle of any operation. The controller never accepts in RD_CMD.
- Grant (combinational, in accept states only):
  - One valid client: grant it.
  - Both valid: grant the client != last_grant.
  - req_ready[g] = accept state && valid[g]; the other client's ready is 0.
- Acceptance at edge E:
  - Latch addr, we, wdata, owner; last_grant=g.
  - Next state: WRITE if we=1, else RD_CMD.
  - With no acceptance: WRITE→IDLE, RD_DATA→IDLE, RD_CMD→RD_DATA.
- Write: the SRAM samples at edge E+1. Write throughput is 1 per cycle back-to-back.
- Read:
  - SRAM samples at E+1 (RD_CMD); macro output becomes valid DELAY after E+1 while oeb=0.
  - Controller samples sram_data at E+2 into rsp<owner>_rdata and asserts rsp<owner>_valid high for exactly cycle E+2..E+3.
  - rdata holds its value until the next read for that client.
  - Read throughput is 1 per 2 cycles.
- csb stays low through RD_DATA so the macro keeps driving the bus (the duplicate read of the same address is harmless).
- Bus ownership:
  - The controller drives sram_data only in WRITE.
  - oeb=0 only in RD_DATA, where web=1.
  - Both change on the same edge; no cycle has two drivers.
- Timing: clock period must exceed the macro read DELAY (3 time units in the model).
- Client protocol: valid, we, addr and wdata are held until ready. A deasserted valid before ready is permitted and carries no penalty.
- An idle client never blocks the other. Starvation is bounded to one operation when both are continuously valid.

Test Plan:
1. Reset, then client0 writes addr 0x005 data 0xDEADBEEF; then reads 0x005 -> sram_csb=0/web=0 one cycle, data driven; read: rsp0_valid one cycle at E+2, rsp0_rdata=0xDEADBEEF, rsp1_valid never set.
2. Both clients valid from reset: client0 write 0x010=0x11111111, client1 write 0x011=0x22222222 -> client0 granted first, client1 next cycle; writes on consecutive cycles; readback returns both values to their correct clients.
3. Both clients issue continuous reads (c0 addr 0x001, c1 addr 0x002, preloaded 0xA, 0xB) -> grants alternate 0,1,0,1; one accept per 2 cycles; each rsp carries its own address's data.
4. Read immediately followed by a write from the other client -> write accepted in RD_DATA; sram_oeb=1 and controller drives data on the next edge; no X on sram_data in any cycle.
5. Assert rstb low during RD_CMD -> all SRAM controls high and sram_data z immediately; no rsp*_valid; first post-reset tie goes to client0.
6. Write and read at addresses 0x000 and 0x7FF -> correct data; no address wrap or truncation.
